// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte lanes plus MMIO CYCLE counter, TX byte FIFO and STATUS.
// Define DMEM_CYCLE_CNT_EN to build the free-running CYCLE counter; otherwise CYCLE reads as zero.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  we,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;

    typedef enum logic [5:0] {
        REG_CYCLE  = 6'd0,
        REG_TXDATA = 6'd1,
        REG_STATUS = 6'd2
    } mmio_reg_e;

    logic          is_mmio;
    logic [5:0]    reg_sel;
    logic          sel_cycle;
    logic          sel_txdata;
    logic          sel_status;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_rdata;
    logic [31:0]   cycle_rdata;
    logic [31:0]   status_word;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] rd_ptr;
    logic [FW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [4:0]    count_ext;
    logic          overflow;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;

    assign is_mmio    = (daddr[31:8] == 24'hFFFFFF);
    assign reg_sel    = daddr[7:2];
    assign sel_cycle  = is_mmio && (reg_sel == REG_CYCLE);
    assign sel_txdata = is_mmio && (reg_sel == REG_TXDATA);
    assign sel_status = is_mmio && (reg_sel == REG_STATUS);
    assign ram_idx    = daddr[AW+1:2];

    // RAM has no reset so its contents survive rst; upper address bits alias.
    always_ff @(posedge clk) begin
        if (!is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
                end
            end
        end
    end

    assign ram_rdata = mem[ram_idx];

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_q;
    logic        cycle_wr;

    assign cycle_wr = sel_cycle && (we != 4'b0000);

    // A write loads the enabled lanes and replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= 32'd0;
        end else if (cycle_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    cycle_q[8*i +: 8] <= dwdata[8*i +: 8];
                end
            end
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_rdata = cycle_q;
`else
    assign cycle_rdata = 32'd0;
`endif

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign tx_valid   = !fifo_empty;
    assign pop        = tx_valid && tx_ready;
    assign push_req   = sel_txdata && we[0];
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign ovf_clr    = sel_status && we[0] && dwdata[2];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= dwdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Gating with tx_valid keeps tx_data at zero after reset without resetting storage.
    assign tx_data     = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign count_ext   = 5'(count);
    assign status_word = {23'd0, count_ext, 1'b0, overflow, fifo_empty, fifo_full};

    always_comb begin
        drdata = ram_rdata;
        if (is_mmio) begin
            case (reg_sel)
                REG_CYCLE:  drdata = cycle_rdata;
                REG_STATUS: drdata = status_word;
                default:    drdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic against a queue/array model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int FD    = 8;

    localparam logic [31:0] A_CYCLE  = 32'hFFFFFF00;
    localparam logic [31:0] A_TX     = 32'hFFFFFF04;
    localparam logic [31:0] A_STATUS = 32'hFFFFFF08;
    localparam logic [31:0] A_UNMAP  = 32'hFFFFFF0C;

`ifdef DMEM_CYCLE_CNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dwdata = 32'd0;
    logic [3:0]  we = 4'd0;
    logic        tx_ready = 1'b0;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cycle = 32'd0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .daddr(daddr), .dwdata(dwdata), .we(we),
        .drdata(drdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_status();
        int n;
        n = m_q.size();
        return {23'd0, 5'(n), 1'b0, m_ovf, (n == 0), (n == FD)};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        if (a[31:8] == 24'hFFFFFF) begin
            case (a[7:2])
                6'd0:    return CYC_EN ? m_cycle : 32'd0;
                6'd2:    return model_status();
                default: return 32'd0;
            endcase
        end
        idx = int'((a >> 2) % DEPTH);
        return m_ram.exists(idx) ? m_ram[idx] : 32'd0;
    endfunction

    function automatic logic [7:0] model_head();
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        daddr  = a;
        dwdata = d;
        we     = w;
        #1;
    endtask

    // Apply the effect of the current inputs to the model, then advance one clock edge.
    task automatic step();
        logic       is_m;
        logic [5:0] off;
        bit         pop_e, push_e, full_e;
        int         idx;
        logic [31:0] w;
        is_m   = (daddr[31:8] == 24'hFFFFFF);
        off    = daddr[7:2];
        pop_e  = (m_q.size() != 0) && tx_ready;
        push_e = is_m && (off == 6'd1) && we[0];
        full_e = (m_q.size() == FD);
        if (!is_m && we != 4'd0) begin
            idx = int'((daddr >> 2) % DEPTH);
            w = m_ram.exists(idx) ? m_ram[idx] : 32'd0;
            for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = dwdata[8*i +: 8];
            m_ram[idx] = w;
        end
        if (CYC_EN) begin
            if (is_m && off == 6'd0 && we != 4'd0) begin
                for (int i = 0; i < 4; i++) if (we[i]) m_cycle[8*i +: 8] = dwdata[8*i +: 8];
            end else begin
                m_cycle = m_cycle + 32'd1;
            end
        end
        if (push_e && full_e && !pop_e) begin
            m_ovf = 1'b1;
        end else begin
            if (pop_e) void'(m_q.pop_front());
            if (push_e) m_q.push_back(dwdata[7:0]);
        end
        if (is_m && off == 6'd2 && we[0] && dwdata[2]) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++;
        if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_data got=%h exp=00", tx_data); end
        bus(A_STATUS, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'h002) begin bad++; $display("[TB] FAIL reset_status got=%h exp=%h", drdata, 32'h002); end
        @(posedge clk);
        #2 rst = 1'b1;
        bus(A_CYCLE, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_cycle0 got=%h exp=0", drdata); end
        step();
        total++;
        if (drdata !== (CYC_EN ? 32'd1 : 32'd0)) begin bad++; $display("[TB] FAIL reset_cycle1 got=%h exp=%h", drdata, CYC_EN ? 32'd1 : 32'd0); end
    endtask

    task automatic test_cycle();
        logic [31:0] exp;
        bus(A_CYCLE, 32'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (drdata !== model_read(A_CYCLE)) begin bad++; $display("[TB] FAIL cycle_inc got=%h exp=%h", drdata, model_read(A_CYCLE)); end
        end
        bus(A_CYCLE, 32'hFFFFFFFE, 4'hF);
        step();
        bus(A_CYCLE, 32'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       exp = CYC_EN ? 32'hFFFFFFFE : 32'd0;
                1:       exp = CYC_EN ? 32'hFFFFFFFF : 32'd0;
                default: exp = 32'd0;
            endcase
            total++;
            if (drdata !== exp) begin bad++; $display("[TB] FAIL cycle_wrap%0d got=%h exp=%h", i, drdata, exp); end
            step();
        end
        bus(A_CYCLE, 32'h000000AA, 4'b0001);
        step();
        bus(A_CYCLE, 32'd0, 4'd0);
        total++;
        if (drdata !== model_read(A_CYCLE)) begin bad++; $display("[TB] FAIL cycle_lane got=%h exp=%h", drdata, model_read(A_CYCLE)); end
    endtask

    task automatic test_ram_lanes();
        bus(32'h40, 32'h11223344, 4'hF);
        step();
        bus(32'h40, 32'hAABBCCDD, 4'b0101);
        total++;
        if (drdata !== 32'h11223344) begin bad++; $display("[TB] FAIL ram_prewrite got=%h exp=%h", drdata, 32'h11223344); end
        step();
        bus(32'h40, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL ram_lanes got=%h exp=%h", drdata, 32'h11BB33DD); end
        bus(32'h1040, 32'd0, 4'd0);
        total++;
        if (drdata !== model_read(32'h40)) begin bad++; $display("[TB] FAIL ram_alias got=%h exp=%h", drdata, model_read(32'h40)); end
    endtask

    task automatic test_fifo_order();
        logic [7:0] e;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus(A_TX, 32'h41 + i, 4'b0001);
            step();
        end
        bus(A_STATUS, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'h030) begin bad++; $display("[TB] FAIL fifo_status3 got=%h exp=%h", drdata, 32'h030); end
        step();
        total++;
        if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL fifo_hold got=%h/%b exp=41/1", tx_data, tx_valid); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = 8'(8'h41 + i);
            total++;
            if (tx_data !== e || tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL fifo_order%0d got=%h exp=%h", i, tx_data, e); end
            step();
        end
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL fifo_drained got=%b exp=0", tx_valid); end
        total++;
        if (drdata !== 32'h002) begin bad++; $display("[TB] FAIL fifo_status_empty got=%h exp=%h", drdata, 32'h002); end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus(A_TX, 32'h60 + i, 4'b0001);
            step();
        end
        bus(A_STATUS, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'h085) begin bad++; $display("[TB] FAIL ovf_status got=%h exp=%h", drdata, 32'h085); end
        bus(A_STATUS, 32'h4, 4'b0001);
        step();
        bus(A_STATUS, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'h081) begin bad++; $display("[TB] FAIL ovf_clear got=%h exp=%h", drdata, 32'h081); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = 8'(8'h60 + i);
            total++;
            if (tx_data !== e) begin bad++; $display("[TB] FAIL ovf_drain%0d got=%h exp=%h", i, tx_data, e); end
            step();
        end
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] last;
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus(A_TX, 32'h70 + i, 4'b0001);
            step();
        end
        tx_ready = 1'b1;
        bus(A_TX, 32'h55, 4'b0001);
        step();
        bus(A_STATUS, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'h081) begin bad++; $display("[TB] FAIL fullpp_status got=%h exp=%h", drdata, 32'h081); end
        last = 8'h00;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tx_data !== model_head()) begin bad++; $display("[TB] FAIL fullpp_byte%0d got=%h exp=%h", i, tx_data, model_head()); end
            last = tx_data;
            step();
        end
        total++;
        if (last !== 8'h55) begin bad++; $display("[TB] FAIL fullpp_last got=%h exp=55", last); end
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL fullpp_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        bus(A_TX, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'd0) begin bad++; $display("[TB] FAIL txdata_read got=%h exp=0", drdata); end
        bus(A_UNMAP, 32'hFFFFFFFF, 4'hF);
        step();
        bus(A_UNMAP, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'd0) begin bad++; $display("[TB] FAIL unmapped_read got=%h exp=0", drdata); end
        bus(A_STATUS, 32'd0, 4'd0);
        total++;
        if (drdata !== model_status()) begin bad++; $display("[TB] FAIL unmapped_status got=%h exp=%h", drdata, model_status()); end
    endtask

    task automatic test_async_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus(A_TX, 32'h31 + i, 4'b0001);
            step();
        end
        total++;
        if (tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL areset_queued got=%b exp=1", tx_valid); end
        daddr = A_STATUS;
        we    = 4'd0;
        #1 rst = 1'b0;
        m_q.delete();
        m_ovf   = 1'b0;
        m_cycle = 32'd0;
        #1;
        total++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("[TB] FAIL areset_immediate got=%b/%h exp=0/00", tx_valid, tx_data); end
        total++;
        if (drdata !== 32'h002) begin bad++; $display("[TB] FAIL areset_status got=%h exp=%h", drdata, 32'h002); end
        @(posedge clk);
        #2 rst = 1'b1;
        bus(32'h40, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL areset_ram got=%h exp=%h", drdata, 32'h11BB33DD); end
        bus(A_CYCLE, 32'd0, 4'd0);
        total++;
        if (drdata !== 32'd0) begin bad++; $display("[TB] FAIL areset_cycle0 got=%h exp=0", drdata); end
        step();
        total++;
        if (drdata !== model_read(A_CYCLE)) begin bad++; $display("[TB] FAIL areset_cycle1 got=%h exp=%h", drdata, model_read(A_CYCLE)); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        int          op;
        for (int k = 0; k < 16; k++) begin
            bus(32'h100 + 32'(k * 4), $urandom, 4'hF);
            step();
        end
        for (int n = 0; n < 300; n++) begin
            tx_ready = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 5);
            a  = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 7) << 12);
            d  = $urandom;
            w  = 4'd0;
            case (op)
                0: w = 4'($urandom_range(1, 15));
                3: a = A_TX;
                4: begin a = A_STATUS; w = 4'($urandom_range(0, 1)); end
                5: a = A_CYCLE;
                default: ;
            endcase
            if (op == 3) w = 4'b0001;
            bus(a, d, w);
            total++;
            if (drdata !== model_read(a)) begin bad++; $display("[TB] FAIL rand_drdata n=%0d a=%h got=%h exp=%h", n, a, drdata, model_read(a)); end
            total++;
            if (tx_valid !== (m_q.size() != 0)) begin bad++; $display("[TB] FAIL rand_tx_valid n=%0d got=%b exp=%b", n, tx_valid, m_q.size() != 0); end
            total++;
            if (tx_data !== model_head()) begin bad++; $display("[TB] FAIL rand_tx_data n=%0d got=%h exp=%h", n, tx_data, model_head()); end
            step();
        end
        tx_ready = 1'b0;
        bus(32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ram_lanes();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_unmapped();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
